// File: rtl/fft_pkg.sv
// Shared constants, counter-width helper and bank-select type for the FFT parallel-to-serial buffer.
package fft_pkg;

  localparam int unsigned FFT_DW    = 34;
  localparam int unsigned FFT_LANES = 4;
  localparam int unsigned FFT_NPTS  = 16;
  localparam int unsigned FFT_BEATS = FFT_NPTS / FFT_LANES;

  // A counter over a single value still needs one bit to exist as a signal.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned FFT_BEAT_W = cnt_w(FFT_BEATS);
  localparam int unsigned FFT_ADDR_W = cnt_w(FFT_NPTS);

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_sel_e;

endpackage

// File: rtl/fft_p2s_pingpong_if.sv
// Beat-wide input / serial output handshake bundle for fft_p2s_pingpong.
interface fft_p2s_pingpong_if #(
  parameter int unsigned DW    = fft_pkg::FFT_DW,
  parameter int unsigned LANES = fft_pkg::FFT_LANES
);

  logic [LANES*DW-1:0] data_in;
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       data_out;
  logic                out_valid;
  logic                out_ready;
  logic                out_sof;
  logic                out_eof;

  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, out_sof, out_eof
  );

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, data_out, out_valid, out_sof, out_eof
  );

endinterface

// File: rtl/fft_p2s_bank.sv
// One ping-pong bank: LANES-wide beat write port, single-word async read port, full flag.
module fft_p2s_bank
  import fft_pkg::*;
#(
  parameter int unsigned DW    = FFT_DW,
  parameter int unsigned LANES = FFT_LANES,
  parameter int unsigned NPTS  = FFT_NPTS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [cnt_w(NPTS/LANES)-1:0] wr_beat,
  input  logic [LANES*DW-1:0]       wr_data,
  input  logic                      set_full,
  input  logic                      clr_full,
  input  logic [cnt_w(NPTS)-1:0]    rd_addr,
  output logic [DW-1:0]             rd_data,
  output logic                      full
);

  localparam int unsigned ADDR_W = cnt_w(NPTS);

  logic [DW-1:0] mem_q [NPTS];
  logic          full_q;
  logic          full_d;

  always_comb begin
    full_d = full_q;
    if (clr_full) full_d = 1'b0;
    if (set_full) full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full_q <= 1'b0;
    else        full_q <= full_d;
  end

  // Storage is deliberately left out of reset; the full flag alone gates its use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        mem_q[ADDR_W'(wr_beat) * ADDR_W'(LANES) + ADDR_W'(j)] <= wr_data[j*DW +: DW];
      end
    end
  end

  assign rd_data = mem_q[rd_addr];
  assign full    = full_q;

endmodule

// File: rtl/fft_p2s_pingpong.sv
// Ping-pong parallel-to-serial frame buffer; define FFT_P2S_TRANSPOSE_EN for lane-major output order.
module fft_p2s_pingpong
  import fft_pkg::*;
#(
  parameter int unsigned DW    = FFT_DW,
  parameter int unsigned LANES = FFT_LANES,
  parameter int unsigned NPTS  = FFT_NPTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_p2s_pingpong_if.slave    bus
);

  localparam int unsigned BEATS  = NPTS / LANES;
  localparam int unsigned BEAT_W = cnt_w(BEATS);
  localparam int unsigned ADDR_W = cnt_w(NPTS);

  bank_sel_e             wr_ptr_q, wr_ptr_d;
  bank_sel_e             rd_ptr_q, rd_ptr_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DW-1:0]         data_out_q, data_out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sof_q, out_sof_d;
  logic                  out_eof_q, out_eof_d;

  logic [1:0]            full;
  logic [1:0]            wr_en;
  logic [1:0]            set_full;
  logic [1:0]            clr_full;
  logic [1:0][DW-1:0]    rd_data;

  logic                  accept;
  logic                  last_beat;
  logic                  load;
  logic                  last_word;

  assign bus.in_ready = !full[wr_ptr_q];
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_beat    = (beat_cnt_q == BEAT_W'(BEATS - 1));
  assign load         = full[rd_ptr_q] && (!out_valid_q || bus.out_ready);
  assign last_word    = (rd_cnt_q == ADDR_W'(NPTS - 1));

  always_comb begin
`ifdef FFT_P2S_TRANSPOSE_EN
    // Output index m walks lanes slowest: slot = (m mod BEATS)*LANES + m/BEATS.
    rd_addr = ADDR_W'((32'(rd_cnt_q) % BEATS) * LANES + 32'(rd_cnt_q) / BEATS);
`else
    rd_addr = rd_cnt_q;
`endif
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    wr_en       = '0;
    set_full    = '0;
    clr_full    = '0;

    if (accept) begin
      wr_en[wr_ptr_q] = 1'b1;
      if (last_beat) begin
        beat_cnt_d         = '0;
        set_full[wr_ptr_q] = 1'b1;
        wr_ptr_d           = (wr_ptr_q == BANK_A) ? BANK_B : BANK_A;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    // Fill and drain always target different banks, so both may complete on one edge.
    if (load) begin
      data_out_d  = rd_data[rd_ptr_q];
      out_valid_d = 1'b1;
      out_sof_d   = (rd_cnt_q == '0);
      out_eof_d   = last_word;
      if (last_word) begin
        rd_cnt_d           = '0;
        clr_full[rd_ptr_q] = 1'b1;
        rd_ptr_d           = (rd_ptr_q == BANK_A) ? BANK_B : BANK_A;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= BANK_A;
      rd_ptr_q    <= BANK_A;
      beat_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
    end
  end

  fft_p2s_bank #(
    .DW    (DW),
    .LANES (LANES),
    .NPTS  (NPTS)
  ) u_bank_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en[0]),
    .wr_beat  (beat_cnt_q),
    .wr_data  (bus.data_in),
    .set_full (set_full[0]),
    .clr_full (clr_full[0]),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data[0]),
    .full     (full[0])
  );

  fft_p2s_bank #(
    .DW    (DW),
    .LANES (LANES),
    .NPTS  (NPTS)
  ) u_bank_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en[1]),
    .wr_beat  (beat_cnt_q),
    .wr_data  (bus.data_in),
    .set_full (set_full[1]),
    .clr_full (clr_full[1]),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data[1]),
    .full     (full[1])
  );

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;

endmodule
